// File: rtl/riscv_wb_if.sv
// MEM->WB stage bundle: MEM-stage fields and data-memory word in, register-file write port and retire count out.
// The master drives the MEM-stage side. The slave is the writeback stage.
interface riscv_wb_if #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
);
  logic                 i_wb_stall;
  logic                 i_wb_flush;
  logic                 i_wb_valid;
  logic                 i_wb_reg_write;
  logic [1:0]           i_wb_result_src;
  logic [4:0]           i_wb_rd_addr;
  logic [2:0]           i_wb_funct3;
  logic [XLEN-1:0]      i_wb_alu_result;
  logic [XLEN-1:0]      i_wb_pc_plus4;
  logic [XLEN-1:0]      i_wb_rdata;
  logic                 o_wb_reg_write;
  logic [4:0]           o_wb_rd_addr;
  logic [XLEN-1:0]      o_wb_rd_data;
  logic                 o_wb_load_misaligned;
  logic [INSTRET_W-1:0] o_wb_instret;

  modport master (
    output i_wb_stall, i_wb_flush, i_wb_valid, i_wb_reg_write, i_wb_result_src,
           i_wb_rd_addr, i_wb_funct3, i_wb_alu_result, i_wb_pc_plus4, i_wb_rdata,
    input  o_wb_reg_write, o_wb_rd_addr, o_wb_rd_data, o_wb_load_misaligned, o_wb_instret
  );

  modport slave (
    input  i_wb_stall, i_wb_flush, i_wb_valid, i_wb_reg_write, i_wb_result_src,
           i_wb_rd_addr, i_wb_funct3, i_wb_alu_result, i_wb_pc_plus4, i_wb_rdata,
    output o_wb_reg_write, o_wb_rd_addr, o_wb_rd_data, o_wb_load_misaligned, o_wb_instret
  );
endinterface

// File: rtl/riscv_wb.sv
// RV32I writeback stage: the MEM/WB register, load align/extend, result mux, rd write port and 64-bit instret.
// Outputs appear 1 cycle after MEM capture. Stall holds the stage. Flush loads a bubble.
module riscv_wb #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input logic      i_clk,
  input logic      i_rstn,
  riscv_wb_if.slave wb
);
  logic                 valid_q;
  logic                 reg_write_q;
  logic [1:0]           src_q;
  logic [4:0]           rd_q;
  logic [2:0]           funct3_q;
  logic [XLEN-1:0]      alu_q;
  logic [XLEN-1:0]      pc4_q;
  logic [INSTRET_W-1:0] instret;

  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic            misaligned;
  logic            load_misaligned;
  logic [XLEN-1:0] result;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
    end else if (wb.i_wb_flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= '0;
      rd_q        <= '0;
      funct3_q    <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
    end else if (!wb.i_wb_stall) begin
      valid_q     <= wb.i_wb_valid;
      reg_write_q <= wb.i_wb_reg_write;
      src_q       <= wb.i_wb_result_src;
      rd_q        <= wb.i_wb_rd_addr;
      funct3_q    <= wb.i_wb_funct3;
      alu_q       <= wb.i_wb_alu_result;
      pc4_q       <= wb.i_wb_pc_plus4;
    end
  end

  assign off      = alu_q[1:0];
  assign byte_sel = wb.i_wb_rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? wb.i_wb_rdata[31:16] : wb.i_wb_rdata[15:0];

  // Unused funct3 encodings fall back to word behaviour, including its alignment rule.
  always_comb begin
    load_data  = wb.i_wb_rdata;
    misaligned = (off != 2'b00);
    case (funct3_q)
      3'b000: begin
        load_data  = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        misaligned = 1'b0;
      end
      3'b100: begin
        load_data  = {{(XLEN-8){1'b0}}, byte_sel};
        misaligned = 1'b0;
      end
      3'b001: begin
        load_data  = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      3'b101: begin
        load_data  = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = off[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    result = alu_q;
    case (src_q)
      2'b01:   result = load_data;
      2'b10:   result = pc4_q;
      default: result = alu_q;
    endcase
  end

  assign load_misaligned = valid_q & (src_q == 2'b01) & misaligned;

  // Retirement follows the instruction already in WB, so a flush of the incoming slot doesn't cancel it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      instret <= '0;
    else if (valid_q && !wb.i_wb_stall && !load_misaligned)
      instret <= instret + 1'b1;
  end

  assign wb.o_wb_reg_write       = valid_q & reg_write_q & (rd_q != 5'd0) & ~load_misaligned;
  assign wb.o_wb_rd_addr         = rd_q;
  assign wb.o_wb_rd_data         = result;
  assign wb.o_wb_load_misaligned = load_misaligned;
  assign wb.o_wb_instret         = instret;
endmodule

// File: tb/tb_riscv_wb.sv
// Directed testbench for riscv_wb. Each step drives the MEM-stage inputs and advances one edge.
// It then checks the WB outputs with immediate assertions against hand-computed values.
module tb_riscv_wb;
  logic i_clk;
  logic i_rstn;
  int   errors = 0;
  int   checks = 0;

  riscv_wb_if #(.XLEN(32), .INSTRET_W(64)) bus ();

  riscv_wb #(.XLEN(32), .INSTRET_W(64)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .wb     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    bus.i_wb_valid      = v;
    bus.i_wb_reg_write  = rw;
    bus.i_wb_result_src = src;
    bus.i_wb_rd_addr    = rd;
    bus.i_wb_funct3     = f3;
    bus.i_wb_alu_result = alu;
    bus.i_wb_pc_plus4   = pc4;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rstn         = 1'b0;
    bus.i_wb_stall = 1'b0;
    bus.i_wb_flush = 1'b0;
    bus.i_wb_rdata = 32'h80FF_00AA;
    drive(0, 0, 2'b00, 5'd0, 3'b000, 32'h0, 32'h0);
    #2;
    chk("rst_reg_write", 64'(bus.o_wb_reg_write), 64'd0);
    chk("rst_rd_addr",   64'(bus.o_wb_rd_addr), 64'd0);
    chk("rst_rd_data",   64'(bus.o_wb_rd_data), 64'd0);
    chk("rst_misalign",  64'(bus.o_wb_load_misaligned), 64'd0);
    chk("rst_instret",   bus.o_wb_instret, 64'd0);
    #10 i_rstn = 1'b1;

    // ADD x5
    drive(1, 1, 2'b00, 5'd5, 3'b000, 32'h1234_5678, 32'h0);
    tick();
    chk("add_reg_write", 64'(bus.o_wb_reg_write), 64'd1);
    chk("add_rd_addr",   64'(bus.o_wb_rd_addr), 64'd5);
    chk("add_rd_data",   64'(bus.o_wb_rd_data), 64'h1234_5678);
    chk("add_instret0",  bus.o_wb_instret, 64'd0);
    drive(0, 0, 2'b00, 5'd0, 3'b000, 32'h0, 32'h0);
    tick();
    chk("add_instret1",  bus.o_wb_instret, 64'd1);
    chk("bubble_wr",     64'(bus.o_wb_reg_write), 64'd0);

    // Loads from rdata 0x80FF_00AA
    drive(1, 1, 2'b01, 5'd6, 3'b000, 32'h1003, 32'h0);
    tick();
    chk("lb_data",  64'(bus.o_wb_rd_data), 64'hFFFF_FF80);
    chk("lb_wr",    64'(bus.o_wb_reg_write), 64'd1);
    drive(1, 1, 2'b01, 5'd6, 3'b100, 32'h1003, 32'h0);
    tick();
    chk("lbu_data", 64'(bus.o_wb_rd_data), 64'h0000_0080);
    chk("lbu_instret", bus.o_wb_instret, 64'd2);
    drive(1, 1, 2'b01, 5'd6, 3'b001, 32'h1002, 32'h0);
    tick();
    chk("lh_data",  64'(bus.o_wb_rd_data), 64'hFFFF_80FF);
    chk("lh_misal", 64'(bus.o_wb_load_misaligned), 64'd0);

    // Misaligned LW then LH
    drive(1, 1, 2'b01, 5'd6, 3'b010, 32'h1001, 32'h0);
    tick();
    chk("lw_mis_flag",    64'(bus.o_wb_load_misaligned), 64'd1);
    chk("lw_mis_wr",      64'(bus.o_wb_reg_write), 64'd0);
    chk("lw_mis_instret", bus.o_wb_instret, 64'd4);
    drive(1, 1, 2'b01, 5'd6, 3'b001, 32'h1003, 32'h0);
    tick();
    chk("lh_mis_flag",    64'(bus.o_wb_load_misaligned), 64'd1);
    chk("lh_mis_wr",      64'(bus.o_wb_reg_write), 64'd0);
    chk("lh_mis_instret", bus.o_wb_instret, 64'd4);

    // JAL to x0, then JAL to x1
    drive(1, 1, 2'b10, 5'd0, 3'b000, 32'h0, 32'h0000_0104);
    tick();
    chk("x0_wr",      64'(bus.o_wb_reg_write), 64'd0);
    chk("x0_instret", bus.o_wb_instret, 64'd4);
    drive(1, 1, 2'b10, 5'd1, 3'b000, 32'h0, 32'h0000_0104);
    tick();
    chk("jal_data",    64'(bus.o_wb_rd_data), 64'h0000_0104);
    chk("jal_wr",      64'(bus.o_wb_reg_write), 64'd1);
    chk("jal_rd",      64'(bus.o_wb_rd_addr), 64'd1);
    chk("jal_instret", bus.o_wb_instret, 64'd5);

    // Three stalled cycles hold JAL x1 in WB
    drive(1, 1, 2'b00, 5'd7, 3'b000, 32'hAAAA_0001, 32'h0);
    bus.i_wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data",    64'(bus.o_wb_rd_data), 64'h0000_0104);
      chk("stall_wr",      64'(bus.o_wb_reg_write), 64'd1);
      chk("stall_instret", bus.o_wb_instret, 64'd5);
    end
    bus.i_wb_stall = 1'b0;
    tick();
    chk("release_rd",      64'(bus.o_wb_rd_addr), 64'd7);
    chk("release_data",    64'(bus.o_wb_rd_data), 64'hAAAA_0001);
    chk("release_instret", bus.o_wb_instret, 64'd6);

    // Flush wins over stall
    bus.i_wb_stall = 1'b1;
    bus.i_wb_flush = 1'b1;
    tick();
    chk("fl_st_wr",      64'(bus.o_wb_reg_write), 64'd0);
    chk("fl_st_instret", bus.o_wb_instret, 64'd6);
    bus.i_wb_stall = 1'b0;
    bus.i_wb_flush = 1'b0;
    drive(1, 1, 2'b00, 5'd8, 3'b000, 32'h55, 32'h0);
    tick();
    chk("pre_flush_instret", bus.o_wb_instret, 64'd6);
    bus.i_wb_flush = 1'b1;
    tick();
    chk("flush_wr",      64'(bus.o_wb_reg_write), 64'd0);
    chk("flush_instret", bus.o_wb_instret, 64'd7);
    bus.i_wb_flush = 1'b0;

    // Counter wrap
    drive(1, 1, 2'b00, 5'd9, 3'b000, 32'h99, 32'h0);
    tick();
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    chk("preload_instret", bus.o_wb_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(0, 0, 2'b00, 5'd0, 3'b000, 32'h0, 32'h0);
    tick();
    chk("wrap_instret", bus.o_wb_instret, 64'd0);

    // Async reset mid-stream
    drive(1, 1, 2'b00, 5'd10, 3'b000, 32'h10, 32'h0);
    tick();
    chk("pre_rst_wr", 64'(bus.o_wb_reg_write), 64'd1);
    #2 i_rstn = 1'b0;
    #1;
    chk("arst_wr",      64'(bus.o_wb_reg_write), 64'd0);
    chk("arst_rd",      64'(bus.o_wb_rd_addr), 64'd0);
    chk("arst_data",    64'(bus.o_wb_rd_data), 64'd0);
    chk("arst_instret", bus.o_wb_instret, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
